// File: rtl/alarm_pkg.sv
// Shared types and sizing helpers for the alarm arming controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED  = 3'd0,
    EXIT_DLY  = 3'd1,
    ARMED     = 3'd2,
    ENTRY_DLY = 3'd3,
    ALARM     = 3'd4
  } state_t;

  // Width needed to hold (largest cycle count - 1), never below 1 bit.
  function automatic int tmr_width(input int a, input int b, input int c, input int d);
    int mx;
    mx = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    if (d > mx) mx = d;
    return ($clog2(mx) < 1) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/alarm_arm_controller_edge_pulse.sv
// Rising-edge detector; previous value resets high so a level held through reset does not fire.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic p
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= d;
  end

  assign p = d & ~prev_q;

endmodule

// File: rtl/alarm_arm_controller.sv
// Arming controller: exit/entry delays, time-limited siren, code disarm and wrong-code lockout.
module alarm_arm_controller
  import alarm_pkg::*;
#(
  parameter int         EXIT_CYCLES  = 16,
  parameter int         ENTRY_CYCLES = 16,
  parameter int         SIREN_CYCLES = 64,
  parameter int         LOCK_CYCLES  = 32,
  parameter int         MAX_TRIES    = 3,
  parameter logic [3:0] CODE         = 4'hA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       enter,
  input  logic [3:0] code,
  input  logic       trip,
  output logic       m,
  output logic       siren,
  output logic       led_armed,
  output logic       led_delay,
  output logic       led_lock
);

  localparam int TW  = tmr_width(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES, LOCK_CYCLES);
  localparam int TRW = ($clog2(MAX_TRIES + 1) < 1) ? 1 : $clog2(MAX_TRIES + 1);

  localparam logic [TW-1:0]  EXIT_LD  = TW'(EXIT_CYCLES - 1);
  localparam logic [TW-1:0]  ENTRY_LD = TW'(ENTRY_CYCLES - 1);
  localparam logic [TW-1:0]  SIREN_LD = TW'(SIREN_CYCLES - 1);
  localparam logic [TW-1:0]  LOCK_LD  = TW'(LOCK_CYCLES - 1);
  localparam logic [TRW-1:0] TRY_MAX  = TRW'(MAX_TRIES);

  state_t         state_q, state_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [TW-1:0]  ltmr_q, ltmr_d;
  logic [TRW-1:0] tries_q, tries_d;
  logic           lock_d;
  logic           m_q, siren_q, led_armed_q, led_delay_q, led_lock_q;

  logic arm_p, enter_p;
  logic ce, good, bad, active, lockout, tmr_zero;

  edge_pulse u_arm_edge   (.clk(clk), .rst(rst), .d(arm),   .p(arm_p));
  edge_pulse u_enter_edge (.clk(clk), .rst(rst), .d(enter), .p(enter_p));

  assign ce       = enter_p & ~led_lock_q;
  assign good     = ce & (code == CODE);
  assign bad      = ce & ~good;
  assign active   = (state_q == EXIT_DLY) || (state_q == ARMED) || (state_q == ENTRY_DLY);
  assign lockout  = active & bad & ((int'(tries_q) + 1) >= MAX_TRIES);
  assign tmr_zero = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    tries_d = tries_q;
    lock_d  = led_lock_q;
    ltmr_d  = ltmr_q;

    // Lock timer runs independently of the main state timer.
    if (led_lock_q) begin
      if (ltmr_q == '0) lock_d = 1'b0;
      else              ltmr_d = ltmr_q - TW'(1);
    end

    if (active) begin
      if (good) begin
        tries_d = '0;
      end else if (lockout) begin
        tries_d = '0;
        lock_d  = 1'b1;
        ltmr_d  = LOCK_LD;
      end else if (bad) begin
        tries_d = (tries_q == TRY_MAX) ? tries_q : tries_q + TRW'(1);
      end
    end

    case (state_q)
      DISARMED: begin
        if (arm_p) begin
          state_d = EXIT_DLY;
          tmr_d   = EXIT_LD;
        end
      end
      EXIT_DLY: begin
        if (good) state_d = DISARMED;
        else if (lockout) begin
          state_d = ALARM;
          tmr_d   = SIREN_LD;
        end else if (tmr_zero) state_d = ARMED;
        else tmr_d = tmr_q - TW'(1);
      end
      ARMED: begin
        if (good) state_d = DISARMED;
        else if (lockout) begin
          state_d = ALARM;
          tmr_d   = SIREN_LD;
        end else if (trip) begin
          state_d = ENTRY_DLY;
          tmr_d   = ENTRY_LD;
        end
      end
      ENTRY_DLY: begin
        if (good) state_d = DISARMED;
        else if (lockout || tmr_zero) begin
          state_d = ALARM;
          tmr_d   = SIREN_LD;
        end else tmr_d = tmr_q - TW'(1);
      end
      ALARM: begin
        if (good) state_d = DISARMED;
        else if (tmr_zero) state_d = ARMED;
        else tmr_d = tmr_q - TW'(1);
      end
      default: state_d = DISARMED;
    endcase
  end

  // Outputs decode the next state so they land in the same cycle as the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DISARMED;
      tmr_q       <= '0;
      ltmr_q      <= '0;
      tries_q     <= '0;
      m_q         <= 1'b0;
      siren_q     <= 1'b0;
      led_armed_q <= 1'b0;
      led_delay_q <= 1'b0;
      led_lock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ltmr_q      <= ltmr_d;
      tries_q     <= tries_d;
      m_q         <= (state_d == ARMED) || (state_d == ENTRY_DLY) || (state_d == ALARM);
      siren_q     <= (state_d == ALARM);
      led_armed_q <= (state_d == ARMED) || (state_d == ENTRY_DLY) || (state_d == ALARM);
      led_delay_q <= (state_d == EXIT_DLY) || (state_d == ENTRY_DLY);
      led_lock_q  <= lock_d;
    end
  end

  assign m         = m_q;
  assign siren     = siren_q;
  assign led_armed = led_armed_q;
  assign led_delay = led_delay_q;
  assign led_lock  = led_lock_q;

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Scoreboard bench: a behavioural model pushes expected outputs per driven cycle, DUT output pops them.
module tb_alarm_arm_controller;

  localparam int         EXIT_C  = 4;
  localparam int         ENTRY_C = 3;
  localparam int         SIREN_C = 5;
  localparam int         LOCK_C  = 6;
  localparam int         MAXT    = 3;
  localparam logic [3:0] CODE_P  = 4'hA;

  localparam int S_DIS = 0, S_EXIT = 1, S_ARMED = 2, S_ENTRY = 3, S_ALM = 4;

  logic       clk;
  logic       rst, arm, enter, trip;
  logic [3:0] code;
  logic       m, siren, led_armed, led_delay, led_lock;

  alarm_arm_controller #(
    .EXIT_CYCLES(EXIT_C), .ENTRY_CYCLES(ENTRY_C), .SIREN_CYCLES(SIREN_C),
    .LOCK_CYCLES(LOCK_C), .MAX_TRIES(MAXT), .CODE(CODE_P)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .enter(enter), .code(code), .trip(trip),
    .m(m), .siren(siren), .led_armed(led_armed), .led_delay(led_delay), .led_lock(led_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int n_delay, n_siren, n_lock;

  logic [4:0] exp_q[$];

  // Model state: counters count elapsed cycles upward in each timed state.
  int   ms, mc, mtries, mlock;
  logic apv, epv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic a, input logic e,
                            input logic [3:0] c, input logic t, output logic [4:0] ev);
    logic ae, ee, locked, good, badc, act, lo;
    if (r) begin
      ms = S_DIS; mc = 0; mtries = 0; mlock = 0; apv = 1'b1; epv = 1'b1;
      ev = 5'b0;
      return;
    end
    ae = a && !apv;
    ee = e && !epv;
    apv = a;
    epv = e;
    locked = (mlock > 0);
    if (locked) mlock--;
    good = ee && !locked && (c == CODE_P);
    badc = ee && !locked && (c != CODE_P);
    act  = (ms == S_EXIT) || (ms == S_ARMED) || (ms == S_ENTRY);
    lo   = 1'b0;
    if (act && good) mtries = 0;
    else if (act && badc) begin
      mtries++;
      if (mtries >= MAXT) begin
        lo = 1'b1; mtries = 0; mlock = LOCK_C;
      end
    end
    case (ms)
      S_DIS:   if (ae) begin ms = S_EXIT; mc = 0; end
      S_EXIT:  if (good) ms = S_DIS;
               else if (lo) begin ms = S_ALM; mc = 0; end
               else if (mc == EXIT_C - 1) ms = S_ARMED;
               else mc++;
      S_ARMED: if (good) ms = S_DIS;
               else if (lo) begin ms = S_ALM; mc = 0; end
               else if (t) begin ms = S_ENTRY; mc = 0; end
      S_ENTRY: if (good) ms = S_DIS;
               else if (lo || mc == ENTRY_C - 1) begin ms = S_ALM; mc = 0; end
               else mc++;
      default: if (good) ms = S_DIS;
               else if (mc == SIREN_C - 1) ms = S_ARMED;
               else mc++;
    endcase
    ev = {ms >= S_ARMED, ms == S_ALM, ms >= S_ARMED, (ms == S_EXIT) || (ms == S_ENTRY), mlock > 0};
  endtask

  task automatic cyc(input logic r, input logic a, input logic e, input logic [3:0] c, input logic t);
    logic [4:0] ev, got;
    rst = r; arm = a; enter = e; code = c; trip = t;
    model_step(r, a, e, c, t, ev);
    exp_q.push_back(ev);
    @(posedge clk);
    #1;
    got = {m, siren, led_armed, led_delay, led_lock};
    if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk("outs{m,siren,armed,delay,lock}", 32'(got), 32'(exp_q.pop_front()));
    if (led_delay) n_delay++;
    if (siren)     n_siren++;
    if (led_lock)  n_lock++;
  endtask

  task automatic idle(input int n, input logic a);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic key(input logic [3:0] c);
    cyc(1'b0, 1'b0, 1'b1, c, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, c, 1'b0);
  endtask

  task automatic clr_cnt();
    n_delay = 0; n_siren = 0; n_lock = 0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; enter = 1'b0; code = 4'h0; trip = 1'b0;
    clr_cnt();
    @(negedge clk);

    // 1 reset with arm held high; no arming after release
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("rst_outs", 32'({m, siren, led_armed, led_delay, led_lock}), 32'd0);
    idle(3, 1'b1);
    chk("rst_hold_delay", 32'(led_delay), 32'd0);
    idle(1, 1'b0);

    // 2 arm with trip pulses during exit delay
    clr_cnt();
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    idle(3, 1'b0);
    chk("exit_len", 32'(n_delay), 32'(EXIT_C));
    chk("armed_m", 32'({m, led_armed}), 32'b11);

    // 3 entry delay, full siren, back to ARMED
    clr_cnt();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    idle(12, 1'b0);
    chk("entry_len", 32'(n_delay), 32'(ENTRY_C));
    chk("siren_len", 32'(n_siren), 32'(SIREN_C));
    chk("rearm", 32'({m, siren}), 32'b10);

    // 4 good code on the last entry-delay cycle beats the timeout
    clr_cnt();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    idle(2, 1'b0);
    key(CODE_P);
    idle(6, 1'b0);
    chk("race_siren", 32'(n_siren), 32'd0);
    chk("race_disarm", 32'({m, led_armed}), 32'b00);

    // 5 wrong codes -> lockout alarm; code ignored during lock, accepted after
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(EXIT_C + 1, 1'b0);
    clr_cnt();
    key(4'h3);
    key(4'h3);
    cyc(1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
    chk("lock_alarm", 32'({siren, led_lock}), 32'b11);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    key(CODE_P);
    idle(8, 1'b0);
    chk("lock_len", 32'(n_lock), 32'(LOCK_C + 0));
    chk("lock_ignored", 32'({m, led_lock}), 32'b10);
    key(CODE_P);
    chk("unlock_disarm", 32'(m), 32'd0);

    // 6 reset mid-alarm
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(EXIT_C + 1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    idle(ENTRY_C + 1, 1'b0);
    chk("pre_rst_siren", 32'(siren), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("midrst_outs", 32'({m, siren, led_lock}), 32'd0);
    idle(3, 1'b0);
    chk("midrst_hold", 32'({m, led_delay}), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
